ahb_job_initializer: RTL
========================

Name: ahb_job_initializer

Overview:
- AHB-Lite slave register block. Successor to the single-shot edge-detector initializer.
- Software stages image dimensions, read and write base addresses and filter type, then commits them as a job descriptor into a parametrised queue.
- The block hands descriptors to the edge-detector core over a valid/ready handshake, tracks busy/done status and raises a level interrupt.
- It sits between the AHB bus and the detector control FSM.

Parameters:
- BUSWIDTH, 32, AHB address/data width.
- NUM_JOBS, 4, descriptor queue depth; power of 2, at least 2.
- DIM_BITS, 16, width/height field width; at most BUSWIDTH/2.
- FILT_BITS, 2, filter-type field width.

Ports:
- clk  in  1  system clock (also AHB HCLK).
- n_rst  in  1  asynchronous active-low reset.
- ahb_hsel  in  1  slave select.
- ahb_htrans  in  2  transfer type; NONSEQ=2, SEQ=3 are valid, IDLE/BUSY are ignored.
- ahb_hwrite  in  1  1 = write.
- ahb_haddr  in  BUSWIDTH  address; only [4:2] are decoded.
- ahb_hwdata  in  BUSWIDTH  write data, valid in data phase.
- ahb_hready  in  1  bus-wide ready; address phase is sampled only when high.
- ahb_hrdata  out  BUSWIDTH  read data.
- ahb_hreadyout  out  1  slave ready.
- ahb_hresp  out  1  0 = OKAY, 1 = ERROR.
- job_valid  out  1  queue head valid.
- job_ready  in  1  core accepts head.
- job_width, job_height  out  DIM_BITS each.
- job_rd_addr, job_wr_addr  out  BUSWIDTH each.
- job_filter  out  FILT_BITS.
- core_done  in  1  single-cycle pulse when the current job completes.
- irq  out  1  level interrupt.

Behaviour:
- Register map (word offset = haddr[4:2]):
  - 0 DIM: RW; [2*DIM_BITS-1:DIM_BITS] height, [DIM_BITS-1:0] width.
  - 1 RD_ADDR: RW.
  - 2 WR_ADDR: RW.
  - 3 FILTER: RW [FILT_BITS-1:0].
  - 4 CTRL: write-only.
    - bit0 = commit.
    - bit1 = clear done count.
    - bit2 = irq_en (stored; reads back in STATUS bit3).
  - 5 STATUS: RO.
    - bit0 busy.
    - bit1 full.
    - bit2 empty.
    - bit3 irq_en.
    - bit4 sticky error.
    - [15:8] queue count.
    - [23:16] done count.
  - 6, 7: unmapped.
- Address phase: registered when hsel & hready & htrans[1]. Data phase acts on the registered address/write flag and hwdata.
- Reads return data in the data phase with zero wait states. Reads of CTRL return 0.
- Error response is a two-cycle AHB ERROR:
  - cycle 1: hreadyout=0, hresp=1.
  - cycle 2: hreadyout=1, hresp=1.
- Error conditions (no state change, STATUS bit4 set):
  - access to offset 6 or 7;
  - write to STATUS;
  - commit while full;
  - commit with staged width=0 or height=0.
- Otherwise hreadyout=1, hresp=0.
- Commit pushes the staged {width, height, rd_addr, wr_addr, filter} into the FIFO at the data-phase cycle. Staged registers are unchanged by the commit.
- Full is evaluated on the pre-pop count. A commit while full is rejected even if a pop occurs in the same cycle.
- A push into an empty queue makes job_valid=1 on the next cycle.
- FIFO behaviour:
  - job_valid = !empty; job_* always show the head entry.
  - Pop happens when job_valid & job_ready.
  - Simultaneous push and pop keeps the count constant.
  - Pointers wrap modulo NUM_JOBS.
- busy is set on pop and cleared on core_done. If core_done and pop occur in the same cycle, busy stays 1.
- done count increments on core_done and saturates at 255.
- CTRL bit1 clears the done count and takes priority over a simultaneous core_done.
- Writing CTRL bit1 also clears sticky error.
- irq = irq_en & (done count != 0); registered, so it rises one cycle after the increment.
- Reset values:
  - all staged registers, queue, counts, busy, irq_en, error = 0;
  - hrdata = 0, hreadyout = 1, hresp = 0;
  - job_valid = 0, job_* = 0, irq = 0.
- Reset mid-transfer aborts the transfer and flushes the queue.

Test Plan:
- Write DIM=0x00F0_0140, RD=0x1000, WR=0x8000, FILTER=2, commit → next cycle job_valid=1, width=320, height=240, rd=0x1000, wr=0x8000, filter=2; STATUS count=1.
- Commit 4 jobs with job_ready=0, then a 5th → 5th gets a two-cycle ERROR; STATUS full=1, count=4, error=1.
- Set irq_en, pop one job, pulse core_done → busy goes 1 then 0; done count=1; irq=1 next cycle; CTRL bit1 write → irq=0, count=0.
- Queue full, job_ready=1 in the same cycle as a commit → commit is ERROR and count drops to 3.
- Read offset 7 and write STATUS → ERROR response each time; registers are unchanged.
- Assert n_rst low mid-burst with 3 jobs queued → job_valid=0, STATUS reads 0x0000_0004 after release.

Source files
------------

// File: rtl/ahb_job_initializer.sv
// ---------------------------------------------------------------------------
// ahb_job_initializer
//
// AHB-Lite slave that lets software stage an edge-detector job (image
// dimensions, read/write base addresses, filter type) and commit it into a
// small descriptor queue. The queue head is offered to the detector core over
// a valid/ready handshake. The block also tracks busy/done status and drives
// a level interrupt.
//
// Register map (word offset = ahb_haddr[4:2]):
//   0 DIM      RW  [2*DIM_BITS-1:DIM_BITS] height, [DIM_BITS-1:0] width
//   1 RD_ADDR  RW
//   2 WR_ADDR  RW
//   3 FILTER   RW  [FILT_BITS-1:0]
//   4 CTRL     WO  bit0 commit, bit1 clear done count + sticky error,
//                  bit2 irq_en (reads as 0)
//   5 STATUS   RO  bit0 busy, bit1 full, bit2 empty, bit3 irq_en,
//                  bit4 sticky error, [15:8] queue count, [23:16] done count
//   6,7        unmapped (ERROR response)
//
// Ports:
//   clk, n_rst               clock (HCLK) and async active-low reset
//   ahb_hsel .. ahb_hready   AHB-Lite slave inputs
//   ahb_hrdata, ahb_hreadyout, ahb_hresp   AHB-Lite slave outputs
//   job_valid, job_ready     descriptor handshake towards the core
//   job_width .. job_filter  head-of-queue descriptor fields
//   core_done                one-cycle pulse when the core finishes a job
//   irq                      level interrupt (irq_en & done count != 0)
//
// STATUS packs the queue and done counts into fixed byte lanes, so BUSWIDTH
// is expected to be at least 24 and NUM_JOBS at most 128.
// ---------------------------------------------------------------------------
module ahb_job_initializer #(
    parameter int BUSWIDTH  = 32,
    parameter int NUM_JOBS  = 4,
    parameter int DIM_BITS  = 16,
    parameter int FILT_BITS = 2
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 ahb_hsel,
    input  logic [1:0]           ahb_htrans,
    input  logic                 ahb_hwrite,
    input  logic [BUSWIDTH-1:0]  ahb_haddr,
    input  logic [BUSWIDTH-1:0]  ahb_hwdata,
    input  logic                 ahb_hready,
    output logic [BUSWIDTH-1:0]  ahb_hrdata,
    output logic                 ahb_hreadyout,
    output logic                 ahb_hresp,
    output logic                 job_valid,
    input  logic                 job_ready,
    output logic [DIM_BITS-1:0]  job_width,
    output logic [DIM_BITS-1:0]  job_height,
    output logic [BUSWIDTH-1:0]  job_rd_addr,
    output logic [BUSWIDTH-1:0]  job_wr_addr,
    output logic [FILT_BITS-1:0] job_filter,
    input  logic                 core_done,
    output logic                 irq
);

    localparam int PTR_W = $clog2(NUM_JOBS);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [2:0] OFF_DIM    = 3'd0;
    localparam logic [2:0] OFF_RD     = 3'd1;
    localparam logic [2:0] OFF_WR     = 3'd2;
    localparam logic [2:0] OFF_FILT   = 3'd3;
    localparam logic [2:0] OFF_CTRL   = 3'd4;
    localparam logic [2:0] OFF_STATUS = 3'd5;

    // RESP_NORMAL covers OKAY data phases and the first (stalled) ERROR
    // cycle; RESP_ERR_TAIL is the second ERROR cycle with hreadyout high.
    typedef enum logic {
        RESP_NORMAL,
        RESP_ERR_TAIL
    } resp_state_t;

    resp_state_t resp_state;
    resp_state_t resp_next;

    // Registered address phase
    logic       dp_valid;
    logic       dp_write;
    logic [2:0] dp_off;

    // Staged descriptor
    logic [DIM_BITS-1:0]  stage_width;
    logic [DIM_BITS-1:0]  stage_height;
    logic [BUSWIDTH-1:0]  stage_rd_addr;
    logic [BUSWIDTH-1:0]  stage_wr_addr;
    logic [FILT_BITS-1:0] stage_filter;

    // Descriptor queue
    logic [DIM_BITS-1:0]  fifo_width   [NUM_JOBS];
    logic [DIM_BITS-1:0]  fifo_height  [NUM_JOBS];
    logic [BUSWIDTH-1:0]  fifo_rd_addr [NUM_JOBS];
    logic [BUSWIDTH-1:0]  fifo_wr_addr [NUM_JOBS];
    logic [FILT_BITS-1:0] fifo_filter  [NUM_JOBS];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     fifo_count;
    logic                 fifo_full;
    logic                 fifo_empty;

    // Control / status
    logic       irq_en;
    logic       sticky_err;
    logic       busy;
    logic [7:0] done_cnt;

    // Data-phase decode
    logic data_phase;
    logic err_cond;
    logic access_err;
    logic access_ok;
    logic write_ok;
    logic ctrl_write;
    logic push;
    logic pop;
    logic clear_done;

    logic [BUSWIDTH-1:0] status_word;

    // Only haddr[4:2] select a register; htrans[0] only distinguishes SEQ
    // from NONSEQ, which this slave treats identically.
    logic unused_bits;
    assign unused_bits = ^{ahb_haddr[BUSWIDTH-1:5], ahb_haddr[1:0], ahb_htrans[0]};

    // Address phase capture: a new transfer is only accepted while the bus
    // is ready, otherwise the current data phase is still in progress.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            dp_off   <= 3'd0;
        end else if (ahb_hready) begin
            dp_valid <= ahb_hsel & ahb_htrans[1];
            dp_write <= ahb_hwrite;
            dp_off   <= ahb_haddr[4:2];
        end
    end

    assign fifo_full  = (fifo_count == CNT_W'(NUM_JOBS));
    assign fifo_empty = (fifo_count == '0);

    // Error decode; full is the pre-pop value so a commit racing a pop
    // is still rejected.
    always_comb begin
        err_cond = 1'b0;
        if (dp_off == 3'd6 || dp_off == 3'd7) begin
            err_cond = 1'b1;
        end else if (dp_write && dp_off == OFF_STATUS) begin
            err_cond = 1'b1;
        end else if (dp_write && dp_off == OFF_CTRL && ahb_hwdata[0] &&
                     (fifo_full || stage_width == '0 || stage_height == '0)) begin
            err_cond = 1'b1;
        end
    end

    // The error tail cycle must not re-execute the access it belongs to.
    assign data_phase = dp_valid && (resp_state == RESP_NORMAL);
    assign access_err = data_phase & err_cond;
    assign access_ok  = data_phase & ~err_cond;
    assign write_ok   = access_ok & dp_write;
    assign ctrl_write = write_ok & (dp_off == OFF_CTRL);
    assign push       = ctrl_write & ahb_hwdata[0];
    assign clear_done = ctrl_write & ahb_hwdata[1];
    assign pop        = job_valid & job_ready;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            resp_state <= RESP_NORMAL;
        end else begin
            resp_state <= resp_next;
        end
    end

    always_comb begin
        resp_next     = resp_state;
        ahb_hreadyout = 1'b1;
        ahb_hresp     = 1'b0;
        case (resp_state)
            RESP_NORMAL: begin
                if (access_err) begin
                    ahb_hreadyout = 1'b0;
                    ahb_hresp     = 1'b1;
                    resp_next     = RESP_ERR_TAIL;
                end
            end
            RESP_ERR_TAIL: begin
                ahb_hresp = 1'b1;
                resp_next = RESP_NORMAL;
            end
            default: resp_next = RESP_NORMAL;
        endcase
    end

    always_comb begin
        status_word        = '0;
        status_word[0]     = busy;
        status_word[1]     = fifo_full;
        status_word[2]     = fifo_empty;
        status_word[3]     = irq_en;
        status_word[4]     = sticky_err;
        status_word[15:8]  = 8'(fifo_count);
        status_word[23:16] = done_cnt;
    end

    // Zero-wait-state read mux; idle, write and error cycles return 0.
    always_comb begin
        ahb_hrdata = '0;
        if (access_ok && !dp_write) begin
            case (dp_off)
                OFF_DIM: begin
                    ahb_hrdata[DIM_BITS-1:0]          = stage_width;
                    ahb_hrdata[2*DIM_BITS-1:DIM_BITS] = stage_height;
                end
                OFF_RD:     ahb_hrdata = stage_rd_addr;
                OFF_WR:     ahb_hrdata = stage_wr_addr;
                OFF_FILT:   ahb_hrdata[FILT_BITS-1:0] = stage_filter;
                OFF_STATUS: ahb_hrdata = status_word;
                default:    ahb_hrdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            stage_width   <= '0;
            stage_height  <= '0;
            stage_rd_addr <= '0;
            stage_wr_addr <= '0;
            stage_filter  <= '0;
        end else if (write_ok) begin
            case (dp_off)
                OFF_DIM: begin
                    stage_width  <= ahb_hwdata[DIM_BITS-1:0];
                    stage_height <= ahb_hwdata[2*DIM_BITS-1:DIM_BITS];
                end
                OFF_RD:   stage_rd_addr <= ahb_hwdata;
                OFF_WR:   stage_wr_addr <= ahb_hwdata;
                OFF_FILT: stage_filter  <= ahb_hwdata[FILT_BITS-1:0];
                default: ;
            endcase
        end
    end

    // Circular descriptor queue; pointers wrap naturally because NUM_JOBS
    // is a power of two.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < NUM_JOBS; i++) begin
                fifo_width[i]   <= '0;
                fifo_height[i]  <= '0;
                fifo_rd_addr[i] <= '0;
                fifo_wr_addr[i] <= '0;
                fifo_filter[i]  <= '0;
            end
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                fifo_width[wr_ptr]   <= stage_width;
                fifo_height[wr_ptr]  <= stage_height;
                fifo_rd_addr[wr_ptr] <= stage_rd_addr;
                fifo_wr_addr[wr_ptr] <= stage_wr_addr;
                fifo_filter[wr_ptr]  <= stage_filter;
                wr_ptr               <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    assign job_valid   = ~fifo_empty;
    assign job_width   = fifo_width[rd_ptr];
    assign job_height  = fifo_height[rd_ptr];
    assign job_rd_addr = fifo_rd_addr[rd_ptr];
    assign job_wr_addr = fifo_wr_addr[rd_ptr];
    assign job_filter  = fifo_filter[rd_ptr];

    // A pop in the same cycle as core_done starts the next job, so busy
    // stays set; the CTRL clear wins over a coincident done pulse.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            irq_en     <= 1'b0;
            sticky_err <= 1'b0;
            busy       <= 1'b0;
            done_cnt   <= 8'd0;
            irq        <= 1'b0;
        end else begin
            if (ctrl_write) begin
                irq_en <= ahb_hwdata[2];
            end

            if (access_err) begin
                sticky_err <= 1'b1;
            end else if (clear_done) begin
                sticky_err <= 1'b0;
            end

            if (pop) begin
                busy <= 1'b1;
            end else if (core_done) begin
                busy <= 1'b0;
            end

            if (clear_done) begin
                done_cnt <= 8'd0;
            end else if (core_done && done_cnt != 8'hFF) begin
                done_cnt <= done_cnt + 8'd1;
            end

            irq <= irq_en & (done_cnt != 8'd0);
        end
    end

endmodule
